// File: rtl/gamma_lut_loader_if.sv
// Valid/ready stream carrying LUT words from the host source into gamma_lut_loader.
// master = word source, slave = loader.
interface gamma_lut_loader_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;

  modport master (output src_valid, output src_data, input src_ready);
  modport slave  (input src_valid, input src_data, output src_ready);
endinterface

// File: rtl/gamma_lut_loader.sv
// Runtime reload sequencer for the gamma corrector LUTs: bypass, drain, stream 2^DATA_WIDTH words per plane.
// Optional watchdog on a stalled source: define GAMMA_LDR_TIMEOUT_EN.
module gamma_lut_loader #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUMCP        = 3,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_req,
  input  logic [NUMCP-1:0]      cp_mask,
  input  logic                  abort,
  gamma_lut_loader_if.slave     src,
  output logic                  gcen,
  output logic [NUMCP-1:0]      lut_wren,
  output logic [DATA_WIDTH-1:0] lut_val,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned          CW         = DATA_WIDTH + 1;
  localparam logic [CW-1:0]        LAST_WORD  = CW'((1 << DATA_WIDTH) - 1);
  localparam int unsigned          DCW        = ($clog2(DRAIN_CYCLES) > 0) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0]       DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, SEL, LOAD, FIN} state_t;

  state_t           state, state_nxt;
  logic [NUMCP-1:0] mask_q, plane_q, low_bit;
  logic [CW-1:0]    word_cnt;
  logic [DCW-1:0]   drain_cnt;
  logic             accept, last_beat, start, kill, timeout_hit;

`ifdef GAMMA_LDR_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              stall_cnt <= '0;
    else if (state != LOAD || src.src_valid) stall_cnt <= '0;
    else                                    stall_cnt <= stall_cnt + TW'(1);
  end

  assign timeout_hit = (state == LOAD) && !src.src_valid && (stall_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    src.src_ready = (state == LOAD);
    busy          = (state != IDLE);
    low_bit       = mask_q & (~mask_q + NUMCP'(1));
    accept        = (state == LOAD) && src.src_valid;
    last_beat     = accept && (word_cnt == LAST_WORD);
    start         = (state == IDLE) && load_req && (cp_mask != '0);
    kill          = (state != IDLE) && (abort || timeout_hit);
    case (state)
      IDLE:    if (start) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = SEL;
      SEL:     state_nxt = LOAD;
      LOAD:    if (last_beat) state_nxt = (mask_q != '0) ? SEL : FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort/timeout wins over every transition, including FIN's completion.
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gcen      <= 1'b1;
      lut_wren  <= '0;
      lut_val   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mask_q    <= '0;
      plane_q   <= '0;
      word_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      done     <= 1'b0;
      lut_wren <= '0;
      if (start) begin
        mask_q    <= cp_mask;
        err       <= 1'b0;
        gcen      <= 1'b0;
        drain_cnt <= '0;
      end
      if (state == IDLE && load_req && cp_mask == '0) done <= 1'b1;
      if (state == DRAIN) drain_cnt <= drain_cnt + DCW'(1);
      if (state == SEL) begin
        plane_q  <= low_bit;
        mask_q   <= mask_q & ~low_bit;
        word_cnt <= '0;
      end
      if (accept && !kill) begin
        word_cnt <= word_cnt + CW'(1);
        lut_wren <= plane_q;
        lut_val  <= src.src_data;
      end
      // gcen stays low after an abort: the LUT contents are only partially written.
      if (state == FIN && !kill) begin
        gcen <= 1'b1;
        done <= 1'b1;
      end
      if (kill) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gamma_lut_loader.sv
// Directed bench for gamma_lut_loader: full/bursty loads, abort, ignored requests, async reset, watchdog.
module tb_gamma_lut_loader;
  localparam int DW    = 8;
  localparam int NCP   = 3;
  localparam int DRAIN = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic           load_req = 1'b0;
  logic           abort = 1'b0;
  logic [NCP-1:0] cp_mask = '0;
  logic           gcen, busy, done, err;
  logic [NCP-1:0] lut_wren;
  logic [DW-1:0]  lut_val;
  int             total = 0;
  int             bad = 0;

  gamma_lut_loader_if #(.DATA_WIDTH(DW)) src_if ();

  gamma_lut_loader #(
    .DATA_WIDTH(DW), .NUMCP(NCP), .DRAIN_CYCLES(DRAIN), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn), .load_req(load_req), .cp_mask(cp_mask), .abort(abort),
    .src(src_if), .gcen(gcen), .lut_wren(lut_wren), .lut_val(lut_val),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    src_if.src_valid = 1'b0;
    src_if.src_data  = '0;
    #1 rstn = 1'b0;
    #1;
    total++;
    if ({gcen, src_if.src_ready, lut_wren, lut_val, busy, done, err} !== {1'b1, 1'b0, 3'b000, 8'h00, 3'b000}) begin
      bad++;
      $display("FAIL reset_values: got %b want %b",
               {gcen, src_if.src_ready, lut_wren, lut_val, busy, done, err}, {1'b1, 12'b0, 3'b000});
    end
    tick;
    rstn = 1'b1;
    tick;
    total++;
    if ({gcen, busy, done, err} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_release: got %b want 1000", {gcen, busy, done, err});
    end
  endtask

  task automatic test_full_load;
    logic [2:0] oh;
    src_if.src_valid = 1'b1;
    src_if.src_data  = '0;
    cp_mask = 3'b101; load_req = 1'b1;
    tick;
    load_req = 1'b0; cp_mask = '0;
    total++;
    if ({busy, gcen, src_if.src_ready} !== 3'b100) begin
      bad++;
      $display("FAIL full_start: got %b want 100", {busy, gcen, src_if.src_ready});
    end
    repeat (DRAIN) tick;
    total++;
    if ({busy, src_if.src_ready, lut_wren} !== 5'b10000) begin
      bad++;
      $display("FAIL full_sel: got %b want 10000", {busy, src_if.src_ready, lut_wren});
    end
    tick;
    total++;
    if (src_if.src_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_first_ready: got %b want 1", src_if.src_ready);
    end
    for (int p = 0; p < 2; p++) begin
      oh = (p == 0) ? 3'b001 : 3'b100;
      for (int i = 0; i < 256; i++) begin
        src_if.src_data = 8'(i);
        tick;
        total++;
        if ({lut_wren, lut_val} !== {oh, 8'(i)}) begin
          bad++;
          $display("FAIL full_write p%0d i%0d: got %b/%h want %b/%h", p, i, lut_wren, lut_val, oh, 8'(i));
        end
      end
      if (p == 0) begin
        total++;
        if (src_if.src_ready !== 1'b0) begin
          bad++;
          $display("FAIL full_gap_ready: got %b want 0", src_if.src_ready);
        end
        tick;
        total++;
        if ({lut_wren, src_if.src_ready} !== 4'b0001) begin
          bad++;
          $display("FAIL full_gap_idle: got %b want 0001", {lut_wren, src_if.src_ready});
        end
      end
    end
    src_if.src_valid = 1'b0;
    total++;
    if ({busy, done, gcen, src_if.src_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL full_fin: got %b want 1000", {busy, done, gcen, src_if.src_ready});
    end
    tick;
    total++;
    if ({done, gcen, busy, lut_wren} !== 6'b110000) begin
      bad++;
      $display("FAIL full_done: got %b want 110000", {done, gcen, busy, lut_wren});
    end
    tick;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL full_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_bursty;
    int beats = 0;
    int c = 0;
    src_if.src_valid = 1'b0;
    cp_mask = 3'b010; load_req = 1'b1;
    tick;
    load_req = 1'b0; cp_mask = '0;
    repeat (DRAIN + 1) tick;
    total++;
    if (src_if.src_ready !== 1'b1) begin
      bad++;
      $display("FAIL bursty_ready: got %b want 1", src_if.src_ready);
    end
    while (beats < 256) begin
      src_if.src_valid = (c % 3 == 0);
      src_if.src_data  = 8'(beats) ^ 8'h5A;
      tick;
      total++;
      if (c % 3 == 0) begin
        if ({lut_wren, lut_val} !== {3'b010, 8'(beats) ^ 8'h5A}) begin
          bad++;
          $display("FAIL bursty_write b%0d: got %b/%h want 010/%h", beats, lut_wren, lut_val, 8'(beats) ^ 8'h5A);
        end
        beats++;
      end else if (lut_wren !== 3'b000) begin
        bad++;
        $display("FAIL bursty_nowrite c%0d: got %b want 000", c, lut_wren);
      end
      c++;
    end
    src_if.src_valid = 1'b0;
    tick;
    total++;
    if ({done, gcen, busy} !== 3'b110) begin
      bad++;
      $display("FAIL bursty_done: got %b want 110", {done, gcen, busy});
    end
  endtask

  task automatic test_zero_mask;
    tick;
    load_req = 1'b1; cp_mask = 3'b000;
    tick;
    load_req = 1'b0;
    total++;
    if ({done, busy, gcen} !== 3'b101) begin
      bad++;
      $display("FAIL zero_mask_done: got %b want 101", {done, busy, gcen});
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if ({done, busy, gcen, err} !== 4'b0010) begin
      bad++;
      $display("FAIL zero_mask_after/idle_abort: got %b want 0010", {done, busy, gcen, err});
    end
  endtask

  task automatic test_abort;
    src_if.src_valid = 1'b1;
    cp_mask = 3'b011; load_req = 1'b1;
    tick;
    load_req = 1'b0; cp_mask = '0;
    repeat (DRAIN + 1) tick;
    for (int i = 0; i < 100; i++) begin
      src_if.src_data = 8'(i);
      tick;
    end
    total++;
    if ({lut_wren, lut_val} !== {3'b001, 8'd99}) begin
      bad++;
      $display("FAIL abort_prewrite: got %b/%h want 001/63", lut_wren, lut_val);
    end
    abort = 1'b1; src_if.src_data = 8'hEE;
    tick;
    abort = 1'b0; src_if.src_valid = 1'b0;
    total++;
    if ({busy, err, gcen, lut_wren, src_if.src_ready, done} !== 8'b01000000) begin
      bad++;
      $display("FAIL abort_next: got %b want 01000000", {busy, err, gcen, lut_wren, src_if.src_ready, done});
    end
    repeat (3) begin
      tick;
      total++;
      if ({done, lut_wren, gcen, busy, err} !== 7'b0000001) begin
        bad++;
        $display("FAIL abort_quiet: got %b want 0000001", {done, lut_wren, gcen, busy, err});
      end
    end
    cp_mask = 3'b001; load_req = 1'b1;
    tick;
    load_req = 1'b0; cp_mask = '0;
    total++;
    if ({err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL abort_err_clear: got %b want 01", {err, busy});
    end
  endtask

  // Continues the plane-0 load started at the end of test_abort.
  task automatic test_req_during_load;
    repeat (DRAIN + 1) tick;
    total++;
    if (src_if.src_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_ready: got %b want 1", src_if.src_ready);
    end
    src_if.src_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      src_if.src_data = 8'(i) ^ 8'hC3;
      if (i == 50) begin
        load_req = 1'b1; cp_mask = 3'b110;
      end
      tick;
      load_req = 1'b0; cp_mask = '0;
      total++;
      if ({lut_wren, lut_val} !== {3'b001, 8'(i) ^ 8'hC3}) begin
        bad++;
        $display("FAIL req_write i%0d: got %b/%h want 001/%h", i, lut_wren, lut_val, 8'(i) ^ 8'hC3);
      end
    end
    src_if.src_valid = 1'b0;
    tick;
    total++;
    if ({done, gcen, busy} !== 3'b110) begin
      bad++;
      $display("FAIL req_done: got %b want 110", {done, gcen, busy});
    end
  endtask

  task automatic test_reset_mid_load;
    src_if.src_valid = 1'b1;
    cp_mask = 3'b111; load_req = 1'b1;
    tick;
    load_req = 1'b0; cp_mask = '0;
    repeat (DRAIN + 1) tick;
    for (int i = 0; i < 10; i++) begin
      src_if.src_data = 8'(i + 1);
      tick;
    end
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({gcen, src_if.src_ready, lut_wren, lut_val, busy, done, err} !== {1'b1, 1'b0, 3'b000, 8'h00, 3'b000}) begin
      bad++;
      $display("FAIL reset_mid_load: got %b want %b",
               {gcen, src_if.src_ready, lut_wren, lut_val, busy, done, err}, {1'b1, 12'b0, 3'b000});
    end
    tick;
    rstn = 1'b1;
    cp_mask = 3'b100; load_req = 1'b1;
    tick;
    load_req = 1'b0; cp_mask = '0;
    total++;
    if ({busy, gcen, err} !== 3'b100) begin
      bad++;
      $display("FAIL reset_reload_start: got %b want 100", {busy, gcen, err});
    end
    repeat (DRAIN + 1) tick;
    for (int i = 0; i < 256; i++) begin
      src_if.src_data = 8'(255 - i);
      tick;
      total++;
      if ({lut_wren, lut_val} !== {3'b100, 8'(255 - i)}) begin
        bad++;
        $display("FAIL reset_reload_write i%0d: got %b/%h want 100/%h", i, lut_wren, lut_val, 8'(255 - i));
      end
    end
    src_if.src_valid = 1'b0;
    tick;
    total++;
    if ({done, gcen, busy, err} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_reload_done: got %b want 1100", {done, gcen, busy, err});
    end
  endtask

`ifdef GAMMA_LDR_TIMEOUT_EN
  task automatic test_timeout;
    src_if.src_valid = 1'b0;
    cp_mask = 3'b001; load_req = 1'b1;
    tick;
    load_req = 1'b0; cp_mask = '0;
    repeat (DRAIN + 1) tick;
    repeat (15) tick;
    total++;
    if ({busy, err} !== 2'b10) begin
      bad++;
      $display("FAIL timeout_early: got %b want 10", {busy, err});
    end
    tick;
    total++;
    if ({busy, err, gcen, done} !== 4'b0100) begin
      bad++;
      $display("FAIL timeout_hit: got %b want 0100", {busy, err, gcen, done});
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_full_load;
    test_bursty;
    test_zero_mask;
    test_abort;
    test_req_during_load;
    test_reset_mid_load;
`ifdef GAMMA_LDR_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
